// File: rtl/sha256_msg_sequencer_if.sv
// Memory and compression-core bus seen by the message sequencer.
// master = sequencer side, slave = memory/core side.
interface sha256_msg_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [31:0]        mem_write_data;
    logic [31:0]        mem_read_data;
    logic               core_start;
    logic               core_done;
    logic [0:15][31:0]  core_block;
    logic [0:7][31:0]   core_hash;
    logic [0:7][31:0]   core_digest;

    modport master (
        output mem_addr, mem_we, mem_write_data, core_start, core_block, core_hash,
        input  mem_read_data, core_done, core_digest
    );

    modport slave (
        input  mem_addr, mem_we, mem_write_data, core_start, core_block, core_hash,
        output mem_read_data, core_done, core_digest
    );
endinterface

// File: rtl/sha256_msg_sequencer.sv
// Reads a message, pads it into 512-bit blocks, chains the SHA-256 core and writes the digest.
// Latency: 1 + nblk*(20 + core busy) + 8 cycles from start to done.
// Backpressure: waits on core_done; memory is fixed 1-cycle read latency, never stalls.
module sha256_msg_sequencer #(
    parameter int          ADDR_W = 16,
    parameter logic [255:0] IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      msg_addr,
    input  logic [ADDR_W-1:0]      msg_words,
    input  logic [ADDR_W-1:0]      out_addr,
    output logic                   done,
    sha256_msg_sequencer_if.master bus
);
    localparam int JW = ADDR_W + 5;

    typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, SETTLE, WAIT_S, CHAIN, WRITE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] msg_addr_q;
    logic [ADDR_W-1:0] msg_words_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [ADDR_W:0]   nblk_q;
    logic [ADDR_W:0]   blk;
    logic [4:0]        p;
    logic [2:0]        n;

    logic [ADDR_W:0]   blk_nxt;
    logic [JW-1:0]     blk_base;
    logic [JW-1:0]     j_fill;
    logic [JW-1:0]     t_last;
    logic [ADDR_W-1:0] fetch_base;
    logic [31:0]       pad_word;

    // j_fill is the global padded index of the word whose read data arrives this cycle.
    always_comb begin
        blk_nxt    = blk + 1'b1;
        blk_base   = {blk, 4'b0000};
        j_fill     = blk_base + JW'(p) - JW'(1);
        t_last     = {nblk_q, 4'b0000} - JW'(1);
        fetch_base = msg_addr_q + ADDR_W'(blk_base);
        pad_word   = 32'h0;
        if (j_fill < JW'(msg_words_q)) begin
            pad_word = bus.mem_read_data;
        end else if (j_fill == JW'(msg_words_q)) begin
            pad_word = 32'h8000_0000;
        end else if (j_fill == t_last) begin
            pad_word = 32'({msg_words_q, 5'b00000});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            done               <= 1'b1;
            bus.mem_we         <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
            bus.core_start     <= 1'b0;
            bus.core_block     <= '0;
            bus.core_hash      <= IV;
            msg_addr_q         <= '0;
            msg_words_q        <= '0;
            out_addr_q         <= '0;
            nblk_q             <= '0;
            blk                <= '0;
            p                  <= '0;
            n                  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        msg_addr_q    <= msg_addr;
                        msg_words_q   <= msg_words;
                        out_addr_q    <= out_addr;
                        nblk_q        <= (ADDR_W+1)'(({1'b0, msg_words} + (ADDR_W+1)'(18)) >> 4);
                        blk           <= '0;
                        p             <= '0;
                        bus.core_hash <= IV;
                        bus.mem_addr  <= msg_addr;
                        done          <= 1'b0;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    // Addresses run one cycle ahead of the block fill, padding slots included.
                    if (p != 5'd0) begin
                        bus.core_block[4'(p - 5'd1)] <= pad_word;
                    end
                    if (p < 5'd15) begin
                        bus.mem_addr <= fetch_base + ADDR_W'(p + 5'd1);
                    end
                    if (p == 5'd16) begin
                        bus.core_start <= 1'b1;
                        state          <= LAUNCH;
                    end else begin
                        p <= p + 5'd1;
                    end
                end
                LAUNCH: begin
                    bus.core_start <= 1'b0;
                    state          <= SETTLE;
                end
                SETTLE: begin
                    state <= WAIT_S;
                end
                WAIT_S: begin
                    if (bus.core_done) begin
                        state <= CHAIN;
                    end
                end
                CHAIN: begin
                    bus.core_hash <= bus.core_digest;
                    blk           <= blk_nxt;
                    if (blk_nxt == nblk_q) begin
                        n                  <= '0;
                        bus.mem_we         <= 1'b1;
                        bus.mem_addr       <= out_addr_q;
                        bus.mem_write_data <= bus.core_digest[0];
                        state              <= WRITE;
                    end else begin
                        p            <= '0;
                        bus.mem_addr <= msg_addr_q + ADDR_W'({blk_nxt, 4'b0000});
                        state        <= FETCH;
                    end
                end
                WRITE: begin
                    if (n == 3'd7) begin
                        bus.mem_we <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        n                  <= n + 3'd1;
                        bus.mem_addr       <= out_addr_q + ADDR_W'(n + 3'd1);
                        bus.mem_write_data <= bus.core_hash[n + 3'd1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
